// File: rtl/exec_stage.sv
// exec_stage: registered, handshaked execute stage (ALU, branch, load/store).
// Define EXEC_STAGE_MUL_EXT_EN to add an iterative shift-add multiply on opcode 0110.
module exec_stage #(
  parameter int WIDTH   = 16,
  parameter int NUM_GPR = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              instruction,
  input  logic [WIDTH-1:0]         pc,
  input  logic [NUM_GPR*WIDTH-1:0] reg_file,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_target,
  output logic                     mem_req,
  input  logic                     mem_gnt,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic [3:0]               mem_mode,
  input  logic                     mem_rvalid,
  input  logic [WIDTH-1:0]         mem_rdata
);
  typedef enum logic [2:0] {
    IDLE, EXEC, MEM_REQ, MEM_WAIT, DONE
`ifdef EXEC_STAGE_MUL_EXT_EN
    , MUL
`endif
  } state_t;

  state_t           state, state_n;
  logic [15:0]      ins_q;
  logic [WIDTH-1:0] pc_q, a_q, b_q, c_q;
  logic [3:0]       opc;
  logic             is_mem;

  assign opc       = ins_q[15:12];
  assign is_mem    = (opc[3:1] == 3'b001);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Index 0 and out-of-range indices read zero, index 1 aliases the pc.
  function automatic logic [WIDTH-1:0] rd_reg(input logic [2:0] idx);
    rd_reg = '0;
    if (idx == 3'd1) rd_reg = pc;
    for (int g = 0; g < NUM_GPR; g++)
      if (int'(idx) == g + 2) rd_reg = reg_file[g*WIDTH +: WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      ins_q <= instruction;
      pc_q  <= pc;
      a_q   <= rd_reg(instruction[8:6]);
      b_q   <= rd_reg(instruction[5:3]);
      c_q   <= rd_reg(instruction[2:0]);
    end
  end

  logic [WIDTH-1:0] alu_x, alu_y, alu_r, alu_res, ls_addr, br_dst, exec_data;
  logic [2:0]       exec_tgt;
  logic             br_taken;

  always_comb begin
    alu_x   = ins_q[11] ? ~b_q : b_q;
    alu_y   = ins_q[10] ? ~c_q : c_q;
    alu_r   = (opc == 4'b0100) ? (alu_x & alu_y) : (alu_x + alu_y);
    alu_res = ins_q[9] ? ~alu_r : alu_r;
    if (ins_q[11:9] == 3'b100) alu_res = (opc == 4'b0101) ? (b_q ^ c_q) : (b_q >> 1);
    // Both offsets are sign-magnitude, not two's complement.
    ls_addr  = ins_q[2] ? b_q - WIDTH'(ins_q[1:0]) : b_q + WIDTH'(ins_q[1:0]);
    br_dst   = ins_q[5] ? pc_q - WIDTH'(ins_q[4:0]) : pc_q + WIDTH'(ins_q[4:0]);
    br_taken = ((a_q == '0) && ins_q[11]) || (($signed(a_q) > 0) && ins_q[10]) ||
               (($signed(a_q) < 0) && ins_q[9]);
    exec_data = '0;
    exec_tgt  = 3'd0;
    case (opc)
      4'b0100, 4'b0101: begin exec_data = alu_res; exec_tgt = ins_q[8:6]; end
      4'b0001: if (br_taken) begin exec_data = br_dst; exec_tgt = 3'd1; end
      default: ;
    endcase
  end

`ifdef EXEC_STAGE_MUL_EXT_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             mul_last;

  assign acc_n    = mplier[0] ? acc + mcand : acc;
  assign mul_last = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      mcand <= b_q; mplier <= c_q; acc <= '0; cnt <= '0;
    end else if (state == MUL) begin
      mcand <= mcand << 1; mplier <= mplier >> 1; acc <= acc_n; cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (in_valid) state_n = EXEC;
      EXEC: begin
        state_n = DONE;
        if (is_mem) state_n = MEM_REQ;
`ifdef EXEC_STAGE_MUL_EXT_EN
        if (opc == 4'b0110) state_n = MUL;
`endif
      end
      MEM_REQ:  if (mem_gnt) state_n = mem_we ? DONE : MEM_WAIT;
      MEM_WAIT: if (mem_rvalid) state_n = DONE;
      DONE:     if (out_ready) state_n = IDLE;
`ifdef EXEC_STAGE_MUL_EXT_EN
      MUL:      if (mul_last) state_n = DONE;
`endif
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0; out_target <= 3'd0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0; mem_mode <= 4'd0;
    end else begin
      case (state)
        EXEC: begin
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= opc[0];
            mem_addr  <= ls_addr;
            mem_wdata <= a_q;
            mem_mode  <= {ins_q[11:9], ins_q[11:10] == 2'b00};
          end else begin
            out_data   <= exec_data;
            out_target <= exec_tgt;
          end
        end
        MEM_REQ: if (mem_gnt) begin
          mem_req <= 1'b0;
          if (mem_we) begin out_data <= a_q; out_target <= 3'd0; end
        end
        MEM_WAIT: if (mem_rvalid) begin
          out_data   <= mem_rdata;
          out_target <= ins_q[8:6];
        end
`ifdef EXEC_STAGE_MUL_EXT_EN
        MUL: if (mul_last) begin
          out_data   <= acc_n;
          out_target <= ins_q[8:6];
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases plus randomized ops vs. an arithmetic model.
module tb_exec_stage;
  localparam int W = 16, NG = 6;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [15:0] instruction;
  logic [W-1:0] pc, out_data, mem_addr, mem_wdata, mem_rdata;
  logic [NG*W-1:0] reg_file;
  logic [2:0] out_target;
  logic [3:0] mem_mode;
  logic [15:0] r [8];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  exec_stage #(.WIDTH(W), .NUM_GPR(NG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .reg_file(reg_file),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_target(out_target),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  task automatic step(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_regs();
    for (int g = 0; g < NG; g++) reg_file[g*W +: W] = r[g+2];
  endtask

  // Inputs change after capture; the DUT must not notice.
  task automatic scramble();
    for (int g = 0; g < NG; g++) reg_file[g*W +: W] = 16'($urandom);
    pc = 16'($urandom);
    instruction = 16'($urandom);
  endtask

  function automatic int opnd(input int idx, input int pcv);
    if (idx == 0) return 0;
    if (idx == 1) return pcv;
    return int'(r[idx]);
  endfunction

  task automatic model_exec(input logic [15:0] ins, input int pcv, output int data, output int tgt);
    int op, a, b, c, x, y, rr, sa, off;
    op = int'(ins[15:12]);
    a = opnd(int'(ins[8:6]), pcv); b = opnd(int'(ins[5:3]), pcv); c = opnd(int'(ins[2:0]), pcv);
    data = 0; tgt = 0;
    if (op == 4 || op == 5) begin
      tgt = int'(ins[8:6]);
      if (ins[11:9] == 3'b100) data = (op == 5) ? (b ^ c) : b / 2;
      else begin
        x = ins[11] ? 65535 - b : b;
        y = ins[10] ? 65535 - c : c;
        rr = (op == 4) ? (x & y) : (x + y) % 65536;
        data = ins[9] ? 65535 - rr : rr;
      end
    end else if (op == 1) begin
      sa = (a >= 32768) ? a - 65536 : a;
      off = ins[5] ? -int'(ins[4:0]) : int'(ins[4:0]);
      if ((sa == 0 && ins[11]) || (sa > 0 && ins[10]) || (sa < 0 && ins[9])) begin
        tgt = 1;
        data = ((pcv + off) % 65536 + 65536) % 65536;
      end
    end
`ifdef EXEC_STAGE_MUL_EXT_EN
    else if (op == 6) begin
      tgt = int'(ins[8:6]);
      data = int'((longint'(b) * longint'(c)) % 65536);
    end
`endif
  endtask

  task automatic run_op(input logic [15:0] ins, input logic [15:0] pcv, input int hold);
    int ed, et, n;
    model_exec(ins, int'(pcv), ed, et);
    apply_regs(); instruction = ins; pc = pcv; out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; step(); in_valid = 1'b0; scramble();
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
`ifdef EXEC_STAGE_MUL_EXT_EN
    if (ins[15:12] != 4'b0110) chk("latency", n, 1);
`else
    chk("latency", n, 1);
`endif
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, ed);
    chk("out_target", out_target, et);
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, ed);
      chk("hold_target", out_target, et);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("done_release", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic mem_op(input logic [15:0] ins, input logic [15:0] pcv, input int stall,
                        input int rdly, input logic [15:0] rdv);
    int a, b, mag, addr, mode;
    a = opnd(int'(ins[8:6]), int'(pcv)); b = opnd(int'(ins[5:3]), int'(pcv));
    mag = int'(ins[1:0]);
    addr = ((b + (ins[2] ? -mag : mag)) % 65536 + 65536) % 65536;
    mode = int'(ins[11:9]) * 2 + ((ins[11:10] == 2'b00) ? 1 : 0);
    apply_regs(); instruction = ins; pc = pcv; out_ready = 1'b0;
    in_valid = 1'b1; step(); in_valid = 1'b0; scramble();
    chk("mem_req_exec", mem_req, 0);
    step();
    for (int k = 0; k <= stall; k++) begin
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, ins[12]);
      chk("mem_addr", mem_addr, addr);
      chk("mem_wdata", mem_wdata, a);
      chk("mem_mode", mem_mode, mode);
      chk("mem_no_out", out_valid, 0);
      if (k == stall) begin mem_gnt = 1'b1; mem_rvalid = 1'b0; end
      else begin mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = 16'($urandom); end
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("mem_req_drop", mem_req, 0);
    if (ins[12]) begin
      chk("st_valid", out_valid, 1);
      chk("st_target", out_target, 0);
      chk("st_data", out_data, a);
    end else begin
      for (int d = 0; d < rdly; d++) begin
        chk("ld_wait", out_valid, 0);
        mem_gnt = 1'($urandom);
        step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdv;
      step();
      mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
      chk("ld_valid", out_valid, 1);
      chk("ld_data", out_data, rdv);
      chk("ld_target", out_target, ins[8:6]);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("mem_release", in_ready, 1);
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  opc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; instruction = '0; pc = '0; reg_file = '0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    step(); step(); rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", {out_valid, out_data, out_target}, 0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_mode}, 0);

    r[3] = 16'd5; r[4] = 16'd7;
    run_op(16'h509C, 16'h0010, 0);
    run_op(16'h589C, 16'h0010, 0);

    r[3] = 16'h0100;
    mem_op(16'h209E, 16'h0020, 3, 1, 16'hBEEF);
    r[2] = 16'h1234; r[3] = 16'h0200;
    mem_op(16'h3099, 16'h0020, 0, 0, 16'h0000);

    r[2] = 16'h0000; run_op(16'h18A3, 16'h0040, 0);
    r[2] = 16'h0001; run_op(16'h18A3, 16'h0040, 0);
    r[2] = 16'h8000; run_op(16'h12A3, 16'h0040, 0);

    r[3] = 16'd5; r[4] = 16'd7;
    run_op(16'h509C, 16'h0010, 4);

    // Reset while waiting for load data, then a stray rvalid.
    r[3] = 16'h0300;
    apply_regs(); instruction = 16'h209E; in_valid = 1'b1; step(); in_valid = 1'b0;
    step(); mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstw_state", {out_valid, mem_req, in_ready}, 3'b001);
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; step(); mem_rvalid = 1'b0;
    chk("stray_rvalid", {out_valid, in_ready}, 2'b01);
    step();
    chk("stray_rvalid2", out_valid, 0);

    // Reset while the request is outstanding.
    apply_regs(); in_valid = 1'b1; step(); in_valid = 1'b0; step();
    chk("req_before_rst", mem_req, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("req_after_rst", {mem_req, in_ready}, 2'b01);

`ifdef EXEC_STAGE_MUL_EXT_EN
    r[3] = 16'd300; r[4] = 16'd300;
    run_op(16'h609C, 16'h0000, 0);
    chk("mul_const", out_data, 16'h5F90);
`endif

    for (int it = 0; it < 40; it++) begin
      for (int i = 2; i < 8; i++)
        r[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      opc = 4'($urandom);
      ins = {opc, 12'($urandom)};
      if (opc == 4'b0001 && $urandom_range(0, 2) == 0) r[ins[8:6]] = 16'h0000;
      if (opc == 4'b0010 || opc == 4'b0011)
        mem_op(ins, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 16'($urandom));
      else
        run_op(ins, 16'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Registered, handshaked successor to the combinational instruction executor of the 16-bit CPU core.
- Sits between decode/register read and writeback.
- Captures one instruction per transaction and evaluates ALU/branch ops.
- Runs load/store over a stallable memory request/response port.
- Returns a result and destination for writeback, with configurable data width.

Parameters:
- WIDTH, 16, datapath/pc/memory data width (>=8); all arithmetic modulo 2^WIDTH.
- NUM_GPR, 6, general registers in reg_file (indices 2..NUM_GPR+1; max 6).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage idle, accepts instruction
- instruction  in  16  instruction word
- pc  in  WIDTH  pc of instruction
- reg_file  in  NUM_GPR*WIDTH  register i at [(i-2)*WIDTH +: WIDTH]
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_data  out  WIDTH  result value
- out_target  out  3  destination; 0 = discard, 1 = pc
- mem_req  out  1  memory request
- mem_gnt  in  1  request accepted this cycle
- mem_we  out  1  1 = store
- mem_addr  out  WIDTH  byte address
- mem_wdata  out  WIDTH  store data
- mem_mode  out  4  access mode
- mem_rvalid  in  1  load data valid
- mem_rdata  in  WIDTH  load data

Behaviour:
- Operand read: index 0 reads 0; index 1 reads pc; index >NUM_GPR+1 reads 0.
- Operands: A = reg[ins[8:6]], B = reg[ins[5:3]], C = reg[ins[2:0]].
- Capture: on in_valid&&in_ready, latch instruction, pc, A, B, C. Later reg_file changes are ignored.
- States: IDLE, EXEC, MEM_REQ, MEM_WAIT, DONE (plus MUL with optional feature).
- in_ready = (state==IDLE).
- IDLE -> EXEC on accept.
- EXEC routes: load/store -> MEM_REQ; opcode 0110 with MUL_EXT_EN -> MUL; all else computes the result -> DONE.
- Latency: out_valid is asserted 2 cycles after the accept edge for ALU/branch/NOP/unknown.
- ALU, opcodes 0100 (AND) and 0101 (ADD):
  - x = ins[11] ? ~B : B; y = ins[10] ? ~C : C.
  - r = AND ? x&y : x+y; result = ins[9] ? ~r : r.
  - Override when ins[11:9]==100: ADD gives B^C; AND gives B>>1 (logical).
  - Target = ins[8:6].
- Load/store, opcodes 0010 (load) and 0011 (store):
  - Offset = sign-magnitude: magnitude ins[1:0], negative if ins[2].
  - mem_addr = B + offset; mem_wdata = A; mem_mode = {ins[11:9], ins[11:10]==00}; mem_we = opcode[0].
  - MEM_REQ holds mem_req=1 and all mem_* stable until mem_gnt. mem_req drops the cycle after gnt.
  - Store: gnt -> DONE, target 0, data A.
  - Load: gnt -> MEM_WAIT. mem_rvalid is sampled only in MEM_WAIT (earliest the cycle after gnt). On rvalid, capture mem_rdata -> DONE, target = ins[8:6].
- Branch, opcode 0001:
  - Offset = sign-magnitude: magnitude ins[4:0], negative if ins[5].
  - Flags on signed A: eq = A==0; gt = A>0; lt = A<0.
  - Taken = (eq&ins[11]) | (gt&ins[10]) | (lt&ins[9]).
  - Taken: target 1, data pc+offset. Not taken: target 0, data 0.
- 0000 and unknown opcodes: target 0, data 0.
- DONE: out_valid=1; out_data and out_target held stable until out_ready, then -> IDLE. A new accept is possible the next cycle, so max throughput is one instruction per 3 cycles.
- Reset:
  - State IDLE; in_ready=1.
  - out_valid, out_data, out_target, mem_req, mem_we, mem_addr, mem_wdata, mem_mode all 0.
  - Reset mid-operation abandons the transaction; mem_req is 0 the cycle after reset.
  - A stale mem_rvalid arriving in IDLE is ignored.
- mem_gnt and mem_rvalid outside their sampling states are ignored.

Optional Feature:
- Macro: EXEC_STAGE_MUL_EXT_EN.
- With the macro defined, opcode 0110 = unsigned multiply B*C (low WIDTH bits):
  - Shift-add, one bit per cycle in state MUL, WIDTH cycles, then DONE; target ins[8:6].
  - Early exit when the remaining multiplier is 0.
- Without the macro, 0110 is unknown: target 0, data 0; state MUL and its counter are absent.

Test Plan:
- ADD: reg3=5, reg4=7, ins 0x509C, accept -> out_valid 2 cycles later, out_data 12, out_target 2. Same with ins 0x589C (XOR override) -> out_data 2.
- Load with stall: reg3=0x0100, ins 0x209E -> mem_req, mem_addr 0x00FE, mem_mode 0001, mem_we 0, all held through 3 cycles of mem_gnt=0. Then gnt; rvalid 2 cycles later with 0xBEEF -> out_data 0xBEEF, target 2.
- Store: reg2=0x1234, reg3=0x0200, ins 0x3099 -> mem_we 1, mem_addr 0x0201, mem_wdata 0x1234, mem_mode 0001; after gnt, out_target 0.
- Branch: pc=0x0040, ins 0x18A3. reg2=0 -> target 1, data 0x003D. reg2=1 -> target 0. reg2=0x8000 with ins 0x12A3 -> taken (lt).
- Backpressure: out_ready low 4 cycles after ADD -> out_valid, out_data and out_target stable, in_ready 0; accept possible the cycle after the out_ready handshake.
- Reset during MEM_WAIT: rst 1 cycle -> next cycle out_valid 0, mem_req 0, in_ready 1; a following stray mem_rvalid produces no output. With EXEC_STAGE_MUL_EXT_EN: 0x609C with reg3=300, reg4=300 -> out_data 0x5F90.
